// File: rtl/fmps_read_links.sv
// FMPS packet receiver for the CCW and CW link taps. Payload words land in a
// per-link DPRAM addressed by FMPS index, and a per-index bitmap tracks which
// indices arrived during the current FA cycle.

// Per-link packet parser with its own payload DPRAM.
module FmpsLinkParser #(
  parameter int          INDEX_WIDTH  = 5,
  parameter logic [15:0] HEADER_MAGIC = 16'hB6CF
) (
  input  logic                      sysClk,
  input  logic                      sysReset_n,
  input  logic                      inhibit,
  input  logic                      tValid,
  input  logic                      tLast,
  input  logic [31:0]               tData,
  input  logic [2**INDEX_WIDTH-1:0] bitmapAll,
  input  logic [INDEX_WIDTH-1:0]    rdAddr,
  output logic [31:0]               rdData,
  output logic                      evValid,
  output logic [2:0]                evCode,
  output logic                      evAccept,
  output logic                      evWrite,
  output logic [INDEX_WIDTH-1:0]    evIndex
);

  typedef enum logic [1:0] {HEADER, DATA, DRAIN} parseState_t;

  parseState_t            state, nextState;
  logic [INDEX_WIDTH-1:0] index;
  logic                   latchIndex;
  logic [31:0]            ram [2**INDEX_WIDTH];

  assign evIndex = index;
  assign rdData  = ram[rdAddr];

  // Classify the current beat; an inhibited link only tracks packet framing.
  always_comb begin
    nextState  = state;
    latchIndex = 1'b0;
    evValid    = 1'b0;
    evCode     = 3'd0;
    evAccept   = 1'b0;
    evWrite    = 1'b0;
    if (tValid) begin
      if (inhibit) begin
        nextState = tLast ? HEADER : DRAIN;
      end else begin
        case (state)
          HEADER: begin
            if (tData[31:16] != HEADER_MAGIC) begin
              evValid   = 1'b1;
              evCode    = 3'd1;
              nextState = tLast ? HEADER : DRAIN;
            end else begin
              latchIndex = 1'b1;
              if (tLast) begin
                evValid = 1'b1;
                evCode  = 3'd2;
              end else begin
                nextState = DATA;
              end
            end
          end
          DATA: begin
            evValid = 1'b1;
            if (tLast) begin
              evWrite   = 1'b1;
              nextState = HEADER;
              if (bitmapAll[index]) begin
                evCode = 3'd4;
              end else begin
                evCode   = 3'd0;
                evAccept = 1'b1;
              end
            end else begin
              evCode    = 3'd3;
              nextState = DRAIN;
            end
          end
          DRAIN: begin
            if (tLast) nextState = HEADER;
          end
          default: nextState = HEADER;
        endcase
      end
    end
  end

  // Parser state and the index captured from the header beat.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state <= HEADER;
      index <= '0;
    end else begin
      state <= nextState;
      if (latchIndex) index <= tData[10 +: INDEX_WIDTH];
    end
  end

  // Payload store; contents survive reset.
  always_ff @(posedge sysClk) begin
    if (evWrite) ram[index] <= tData;
  end

endmodule

module fmps_read_links #(
  parameter int          INDEX_WIDTH  = 5,
  parameter int          SYSCLK_RATE  = 100000000,
  parameter logic [15:0] HEADER_MAGIC = 16'hB6CF
) (
  input  logic                      sysClk,
  input  logic                      sysReset_n,
  input  logic                      csrStrobe,
  input  logic [31:0]               GPIO_OUT,
  output logic [31:0]               csr,
  input  logic [2**INDEX_WIDTH-1:0] fmpsEnableMask,
  input  logic                      FAstrobe,
  output logic [2**INDEX_WIDTH-1:0] fmpsBitmapAll,
  output logic [2**INDEX_WIDTH-1:0] fmpsBitmapEnabled,
  output logic                      fmpsEnabled,
  output logic [2**INDEX_WIDTH-1:0] fmpsBitmapAllFASnapshot,
  output logic [2**INDEX_WIDTH-1:0] fmpsEnableBitmapFASnapshot,
  output logic                      sysStatusStrobe,
  output logic [2:0]                sysStatusCode,
  output logic                      sysTimeoutStrobe,
  input  logic [INDEX_WIDTH-1:0]    fmpsReadoutAddress,
  output logic [31:0]               fmpsReadout,
  input  logic                      uBreadoutStrobe,
  output logic [31:0]               uBreadout,
  output logic                      CCWinhibit,
  output logic                      CWinhibit,
  input  logic                      CCWlinkTVALID,
  input  logic                      CCWlinkTLAST,
  input  logic [31:0]               CCWlinkTDATA,
  input  logic                      CWlinkTVALID,
  input  logic                      CWlinkTLAST,
  input  logic [31:0]               CWlinkTDATA
);

  localparam int NIDX    = 2**INDEX_WIDTH;
  localparam int TMO     = SYSCLK_RATE / 10000;
  localparam int TIMER_W = $clog2(TMO + 1);
  localparam int INH_BIT = 3 * (INDEX_WIDTH + 1);

  logic [5:0]             expectedCount, ccwCount, cwCount;
  logic                   readoutActive, readoutValid;
  logic [TIMER_W-1:0]     timer;
  logic [NIDX-1:0]        ccwFlag, cwFlag;
  logic [NIDX-1:0]        ccwAcceptMask, cwAcceptMask, ccwWriteMask, cwWriteMask;
  logic [INDEX_WIDTH:0]   popCount;
  logic                   pendingValid;
  logic [2:0]             pendingCode;
  logic                   uBpointer;
  logic [31:0]            ccwRdData, cwRdData;
  logic                   ccwEvValid, ccwEvAccept, ccwEvWrite;
  logic                   cwEvValid, cwEvAccept, cwEvWrite;
  logic [2:0]             ccwEvCode, cwEvCode;
  logic [INDEX_WIDTH-1:0] ccwEvIndex, cwEvIndex;
  logic                   unusedGpioBits;

  assign unusedGpioBits    = ^{GPIO_OUT[31:INH_BIT+2], GPIO_OUT[INH_BIT-1:6]};
  assign fmpsBitmapEnabled = fmpsBitmapAll & fmpsEnableMask;
  assign fmpsEnabled       = |fmpsBitmapEnabled;
  assign csr = {readoutActive, readoutValid, 10'b0, CWinhibit, CCWinhibit,
                cwCount, ccwCount, expectedCount};
  assign uBreadout = uBpointer ? 32'(fmpsEnableBitmapFASnapshot)
                               : 32'(fmpsBitmapAllFASnapshot);

  FmpsLinkParser #(.INDEX_WIDTH(INDEX_WIDTH), .HEADER_MAGIC(HEADER_MAGIC)) ccwParser (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .inhibit(CCWinhibit),
    .tValid(CCWlinkTVALID), .tLast(CCWlinkTLAST), .tData(CCWlinkTDATA),
    .bitmapAll(fmpsBitmapAll), .rdAddr(fmpsReadoutAddress), .rdData(ccwRdData),
    .evValid(ccwEvValid), .evCode(ccwEvCode), .evAccept(ccwEvAccept),
    .evWrite(ccwEvWrite), .evIndex(ccwEvIndex)
  );

  FmpsLinkParser #(.INDEX_WIDTH(INDEX_WIDTH), .HEADER_MAGIC(HEADER_MAGIC)) cwParser (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .inhibit(CWinhibit),
    .tValid(CWlinkTVALID), .tLast(CWlinkTLAST), .tData(CWlinkTDATA),
    .bitmapAll(fmpsBitmapAll), .rdAddr(fmpsReadoutAddress), .rdData(cwRdData),
    .evValid(cwEvValid), .evCode(cwEvCode), .evAccept(cwEvAccept),
    .evWrite(cwEvWrite), .evIndex(cwEvIndex)
  );

  // One-hot masks of the indices each link stores or newly accepts this cycle, plus bitmap population.
  always_comb begin
    ccwWriteMask  = ccwEvWrite  ? ({{(NIDX-1){1'b0}}, 1'b1} << ccwEvIndex) : '0;
    cwWriteMask   = cwEvWrite   ? ({{(NIDX-1){1'b0}}, 1'b1} << cwEvIndex)  : '0;
    ccwAcceptMask = ccwEvAccept ? ccwWriteMask : '0;
    cwAcceptMask  = cwEvAccept  ? cwWriteMask  : '0;
    popCount      = '0;
    for (int i = 0; i < NIDX; i++) begin
      popCount = popCount + {{INDEX_WIDTH{1'b0}}, fmpsBitmapAll[i]};
    end
  end

  // CSR fields written by the control processor.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      expectedCount <= '0;
      CCWinhibit    <= 1'b0;
      CWinhibit     <= 1'b0;
    end else if (csrStrobe) begin
      expectedCount <= GPIO_OUT[5:0];
      CCWinhibit    <= GPIO_OUT[INH_BIT];
      CWinhibit     <= GPIO_OUT[INH_BIT+1];
    end
  end

  // FA-cycle bookkeeping: snapshots, bitmap, link flags, counts and the acquisition timer.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      fmpsBitmapAll              <= '0;
      fmpsBitmapAllFASnapshot    <= '0;
      fmpsEnableBitmapFASnapshot <= '0;
      ccwFlag                    <= '0;
      cwFlag                     <= '0;
      ccwCount                   <= '0;
      cwCount                    <= '0;
      readoutActive              <= 1'b0;
      readoutValid               <= 1'b0;
      timer                      <= '0;
      sysTimeoutStrobe           <= 1'b0;
    end else if (FAstrobe) begin
      fmpsBitmapAllFASnapshot    <= fmpsBitmapAll;
      fmpsEnableBitmapFASnapshot <= fmpsBitmapEnabled;
      fmpsBitmapAll              <= '0;
      ccwFlag                    <= '0;
      cwFlag                     <= '0;
      ccwCount                   <= '0;
      cwCount                    <= '0;
      readoutActive              <= 1'b1;
      readoutValid               <= 1'b0;
      timer                      <= '0;
      sysTimeoutStrobe           <= readoutActive;
    end else begin
      sysTimeoutStrobe <= 1'b0;
      fmpsBitmapAll    <= fmpsBitmapAll | ccwAcceptMask | cwAcceptMask;
      ccwFlag          <= ccwFlag | ccwWriteMask;
      cwFlag           <= cwFlag | cwWriteMask;
      ccwCount         <= ccwCount + {5'b0, ccwEvAccept};
      cwCount          <= cwCount + {5'b0, cwEvAccept};
      if (readoutActive) begin
        if ((expectedCount != '0) && (32'(popCount) == 32'(expectedCount))) begin
          readoutActive <= 1'b0;
          readoutValid  <= 1'b1;
        end else if (timer == TIMER_W'(TMO - 1)) begin
          readoutActive    <= 1'b0;
          sysTimeoutStrobe <= 1'b1;
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
    end
  end

  // Status reporting; a CW result that collides with a CCW result waits one cycle.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      sysStatusStrobe <= 1'b0;
      sysStatusCode   <= '0;
      pendingValid    <= 1'b0;
      pendingCode     <= '0;
    end else begin
      sysStatusStrobe <= 1'b0;
      if (ccwEvValid) begin
        sysStatusStrobe <= 1'b1;
        sysStatusCode   <= ccwEvCode;
        if (cwEvValid) begin
          pendingValid <= 1'b1;
          pendingCode  <= cwEvCode;
        end
      end else if (pendingValid) begin
        sysStatusStrobe <= 1'b1;
        sysStatusCode   <= pendingCode;
        if (cwEvValid) pendingCode <= cwEvCode;
        else           pendingValid <= 1'b0;
      end else if (cwEvValid) begin
        sysStatusStrobe <= 1'b1;
        sysStatusCode   <= cwEvCode;
      end
    end
  end

  // Registered readout, preferring the CCW copy when CCW delivered that index.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      fmpsReadout <= '0;
    end else begin
      fmpsReadout <= ccwFlag[fmpsReadoutAddress] ? ccwRdData : cwRdData;
    end
  end

  // Microblaze readout word selector.
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      uBpointer <= 1'b0;
    end else if (uBreadoutStrobe) begin
      uBpointer <= ~uBpointer;
    end
  end

endmodule

// File: tb/tb_fmps_read_links.sv
// Directed self-checking bench for fmps_read_links.
module tb_fmps_read_links;

  logic        sysClk = 1'b0;
  logic        sysReset_n;
  logic        csrStrobe;
  logic [31:0] GPIO_OUT;
  logic [31:0] csr;
  logic [31:0] fmpsEnableMask;
  logic        FAstrobe;
  logic [31:0] fmpsBitmapAll, fmpsBitmapEnabled;
  logic        fmpsEnabled;
  logic [31:0] fmpsBitmapAllFASnapshot, fmpsEnableBitmapFASnapshot;
  logic        sysStatusStrobe;
  logic [2:0]  sysStatusCode;
  logic        sysTimeoutStrobe;
  logic [4:0]  fmpsReadoutAddress;
  logic [31:0] fmpsReadout;
  logic        uBreadoutStrobe;
  logic [31:0] uBreadout;
  logic        CCWinhibit, CWinhibit;
  logic        CCWlinkTVALID, CCWlinkTLAST, CWlinkTVALID, CWlinkTLAST;
  logic [31:0] CCWlinkTDATA, CWlinkTDATA;

  int          checkCount = 0;
  int          passCount = 0;
  int          timeoutCount = 0;
  logic [2:0]  statusQ[$];

  typedef struct {
    bit          onCw;
    logic [31:0] hdr;
    bit          hdrLast;
    logic [31:0] dat;
    bit          datLast;
    logic [2:0]  expCode;
    logic [31:0] expBitmap;
  } vec_t;

  vec_t vecs[7];

  fmps_read_links dut (
    .sysClk(sysClk), .sysReset_n(sysReset_n), .csrStrobe(csrStrobe), .GPIO_OUT(GPIO_OUT),
    .csr(csr), .fmpsEnableMask(fmpsEnableMask), .FAstrobe(FAstrobe),
    .fmpsBitmapAll(fmpsBitmapAll), .fmpsBitmapEnabled(fmpsBitmapEnabled),
    .fmpsEnabled(fmpsEnabled), .fmpsBitmapAllFASnapshot(fmpsBitmapAllFASnapshot),
    .fmpsEnableBitmapFASnapshot(fmpsEnableBitmapFASnapshot),
    .sysStatusStrobe(sysStatusStrobe), .sysStatusCode(sysStatusCode),
    .sysTimeoutStrobe(sysTimeoutStrobe), .fmpsReadoutAddress(fmpsReadoutAddress),
    .fmpsReadout(fmpsReadout), .uBreadoutStrobe(uBreadoutStrobe), .uBreadout(uBreadout),
    .CCWinhibit(CCWinhibit), .CWinhibit(CWinhibit),
    .CCWlinkTVALID(CCWlinkTVALID), .CCWlinkTLAST(CCWlinkTLAST), .CCWlinkTDATA(CCWlinkTDATA),
    .CWlinkTVALID(CWlinkTVALID), .CWlinkTLAST(CWlinkTLAST), .CWlinkTDATA(CWlinkTDATA)
  );

  // 100 MHz system clock.
  always #5 sysClk = ~sysClk;

  // Record status and timeout pulses on the falling edge, away from the active edge.
  always @(negedge sysClk) begin
    if (sysReset_n) begin
      if (sysStatusStrobe) statusQ.push_back(sysStatusCode);
      if (sysTimeoutStrobe) timeoutCount++;
    end
  end

  function automatic logic [31:0] hdrWord(input int idx);
    logic [4:0] i5;
    i5 = idx[4:0];
    return {16'hB6CF, 1'b0, i5, 10'b0};
  endfunction

  function automatic logic [31:0] dataWord(input int idx, input int fa);
    logic [4:0] i5;
    logic [7:0] f8;
    i5 = idx[4:0];
    f8 = fa[7:0];
    return {3'b000, i5, 16'hCACA, f8};
  endfunction

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Drive one beat on either or both links for a single cycle.
  task automatic applyStimulus(input bit useCcw, input bit useCw, input logic [31:0] ccwData,
                               input logic [31:0] cwData, input bit last);
    CCWlinkTVALID = useCcw;
    CCWlinkTDATA  = ccwData;
    CCWlinkTLAST  = useCcw & last;
    CWlinkTVALID  = useCw;
    CWlinkTDATA   = cwData;
    CWlinkTLAST   = useCw & last;
    tick();
    CCWlinkTVALID = 1'b0;
    CCWlinkTLAST  = 1'b0;
    CWlinkTVALID  = 1'b0;
    CWlinkTLAST   = 1'b0;
  endtask

  task automatic writeCsr(input logic [31:0] value);
    GPIO_OUT  = value;
    csrStrobe = 1'b1;
    tick();
    csrStrobe = 1'b0;
  endtask

  task automatic pulseFA();
    FAstrobe = 1'b1;
    tick();
    FAstrobe = 1'b0;
    tick();
  endtask

  task automatic pulseUb();
    uBreadoutStrobe = 1'b1;
    tick();
    uBreadoutStrobe = 1'b0;
  endtask

  task automatic checkReadout(input int idx, input logic [31:0] exp);
    fmpsReadoutAddress = idx[4:0];
    tick();
    checkOutput($sformatf("readout[%0d]", idx), fmpsReadout, exp);
  endtask

  // CCW carries indices 0-7 while CW simultaneously carries 8-15.
  task automatic sendPairs(input int fa);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, hdrWord(i), hdrWord(i + 8), 1'b0);
      applyStimulus(1'b1, 1'b1, dataWord(i, fa), dataWord(i + 8, fa), 1'b1);
      tick();
      tick();
    end
  endtask

  initial begin
    int nonZero;

    vecs[0] = '{1'b0, 32'h1234_0000, 1'b0, 32'h0,         1'b1, 3'd1, 32'h0000_FFFF};
    vecs[1] = '{1'b1, 32'h1234_0000, 1'b1, 32'h0,         1'b1, 3'd1, 32'h0000_FFFF};
    vecs[2] = '{1'b0, hdrWord(20),   1'b1, 32'h0,         1'b1, 3'd2, 32'h0000_FFFF};
    vecs[3] = '{1'b1, hdrWord(21),   1'b0, 32'hAAAA_5555, 1'b0, 3'd3, 32'h0000_FFFF};
    vecs[4] = '{1'b1, hdrWord(3),    1'b0, 32'hDEAD_0003, 1'b1, 3'd4, 32'h0000_FFFF};
    vecs[5] = '{1'b0, hdrWord(3),    1'b0, 32'h1234_5678, 1'b1, 3'd4, 32'h0000_FFFF};
    vecs[6] = '{1'b0, hdrWord(16),   1'b0, dataWord(16, 1), 1'b1, 3'd0, 32'h0001_FFFF};

    sysReset_n = 1'b0;
    csrStrobe = 1'b0;
    GPIO_OUT = '0;
    fmpsEnableMask = 32'h0000_00F0;
    FAstrobe = 1'b0;
    fmpsReadoutAddress = '0;
    uBreadoutStrobe = 1'b0;
    CCWlinkTVALID = 1'b0; CCWlinkTLAST = 1'b0; CCWlinkTDATA = '0;
    CWlinkTVALID = 1'b0;  CWlinkTLAST = 1'b0;  CWlinkTDATA = '0;
    repeat (3) tick();

    checkOutput("reset csr", csr, 32'h0);
    checkOutput("reset bitmap", fmpsBitmapAll, 32'h0);
    checkOutput("reset uBreadout", uBreadout, 32'h0);
    checkOutput("reset readout", fmpsReadout, 32'h0);
    checkOutput("reset status", 32'({sysStatusStrobe, sysStatusCode, sysTimeoutStrobe}), 32'h0);
    checkOutput("reset inhibits", 32'({CCWinhibit, CWinhibit}), 32'h0);

    sysReset_n = 1'b1;
    tick();

    // Full acquisition: 16 packets against an expected count of 16.
    writeCsr(32'd16);
    checkOutput("csr expected count", csr, 32'd16);
    pulseFA();
    checkOutput("active after FA", 32'(csr[31]), 32'd1);
    checkOutput("no timeout on first FA", 32'(timeoutCount), 32'd0);
    statusQ.delete();
    sendPairs(1);
    tick();
    tick();
    checkOutput("status pulses", 32'(statusQ.size()), 32'd16);
    nonZero = 0;
    foreach (statusQ[i]) if (statusQ[i] != 3'd0) nonZero++;
    checkOutput("nonzero status codes", 32'(nonZero), 32'd0);
    checkOutput("readoutValid", 32'(csr[30]), 32'd1);
    checkOutput("readoutActive", 32'(csr[31]), 32'd0);
    checkOutput("bitmap full", fmpsBitmapAll, 32'h0000_FFFF);
    checkOutput("ccw count", 32'(csr[11:6]), 32'd8);
    checkOutput("cw count", 32'(csr[17:12]), 32'd8);
    for (int i = 0; i < 16; i++) checkReadout(i, dataWord(i, 1));

    // Table of single-link packets covering every status code.
    for (int v = 0; v < 7; v++) begin
      statusQ.delete();
      applyStimulus(!vecs[v].onCw, vecs[v].onCw, vecs[v].hdr, vecs[v].hdr, vecs[v].hdrLast);
      if (!vecs[v].hdrLast) begin
        applyStimulus(!vecs[v].onCw, vecs[v].onCw, vecs[v].dat, vecs[v].dat, vecs[v].datLast);
        if (!vecs[v].datLast) applyStimulus(!vecs[v].onCw, vecs[v].onCw, 32'h0, 32'h0, 1'b1);
      end
      repeat (3) tick();
      checkOutput($sformatf("vec%0d pulses", v), 32'(statusQ.size()), 32'd1);
      if (statusQ.size() > 0) checkOutput($sformatf("vec%0d code", v), 32'(statusQ[0]), 32'(vecs[v].expCode));
      checkOutput($sformatf("vec%0d bitmap", v), fmpsBitmapAll, vecs[v].expBitmap);
      if (v == 4) checkReadout(3, dataWord(3, 1));
    end
    checkOutput("ccw count after dup", 32'(csr[11:6]), 32'd9);
    checkOutput("cw count after dup", 32'(csr[17:12]), 32'd8);
    checkReadout(3, 32'h1234_5678);
    checkReadout(16, dataWord(16, 1));

    // Simultaneous completions: CCW reported first, CW one cycle later.
    statusQ.delete();
    applyStimulus(1'b1, 1'b1, hdrWord(22), 32'h1234_0000, 1'b1);
    repeat (3) tick();
    checkOutput("collision pulses", 32'(statusQ.size()), 32'd2);
    if (statusQ.size() == 2) begin
      checkOutput("collision first", 32'(statusQ[0]), 32'd2);
      checkOutput("collision second", 32'(statusQ[1]), 32'd1);
    end

    // Expected count 17 can never be met: the timer must expire.
    writeCsr(32'd17);
    pulseFA();
    checkOutput("no timeout after completed cycle", 32'(timeoutCount), 32'd0);
    checkOutput("uB snapshot all", uBreadout, 32'h0001_FFFF);
    pulseUb();
    checkOutput("uB snapshot enabled", uBreadout, 32'h0000_00F0);
    pulseUb();
    sendPairs(2);
    checkOutput("bitmap second cycle", fmpsBitmapAll, 32'h0000_FFFF);
    checkOutput("still active", 32'(csr[31:30]), 32'd2);
    checkReadout(5, dataWord(5, 2));
    for (int i = 0; i < 12000 && timeoutCount == 0; i++) tick();
    checkOutput("timer timeout", 32'(timeoutCount), 32'd1);
    checkOutput("flags after timeout", 32'(csr[31:30]), 32'd0);

    // CW inhibited: only CCW packets count.
    writeCsr(32'h0008_0011);
    checkOutput("inhibit outputs", 32'({CCWinhibit, CWinhibit}), 32'd1);
    checkOutput("csr inhibit bits", 32'(csr[19:18]), 32'd2);
    pulseFA();
    checkOutput("no timeout after expired cycle", 32'(timeoutCount), 32'd1);
    statusQ.delete();
    sendPairs(3);
    checkOutput("inhibited pulses", 32'(statusQ.size()), 32'd8);
    checkOutput("inhibited bitmap", fmpsBitmapAll, 32'h0000_00FF);
    checkOutput("inhibited cw count", 32'(csr[17:12]), 32'd0);
    checkOutput("inhibited ccw count", 32'(csr[11:6]), 32'd8);
    checkOutput("enabled bitmap", fmpsBitmapEnabled, 32'h0000_00F0);
    checkOutput("fmpsEnabled", 32'(fmpsEnabled), 32'd1);

    // Back-to-back FA strobes while still active.
    pulseFA();
    checkOutput("timeout at FA while active", 32'(timeoutCount), 32'd2);
    checkOutput("uB snap all 0xFF", uBreadout, 32'h0000_00FF);
    pulseUb();
    checkOutput("uB snap enabled 0xF0", uBreadout, 32'h0000_00F0);
    pulseFA();
    checkOutput("timeout at second FA", 32'(timeoutCount), 32'd3);
    checkOutput("uB snap enabled empty", uBreadout, 32'h0);
    checkOutput("snapshot all empty", fmpsBitmapAllFASnapshot, 32'h0);
    pulseUb();
    checkOutput("uB pointer back", uBreadout, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
